monolith_chunk_scheduler: RTL

- Sequences the Monolith permutation datapath behind the AXI4-Stream chunk FIFO.
- Waits for a complete chunk in the FIFO, latches it, pops it, and runs it through the permutation core with a start/done handshake.
- Serialises the permuted state word-by-word onto an AXI4-Stream-style result port, with TLAST on the final word.
- Adds a permutation watchdog and a processed-chunk counter for software visibility.

---
 rtl/monolith_chunk_scheduler.sv | 127 ++++++++++++
 1 files changed

// File: rtl/monolith_chunk_scheduler.sv
// Chunk scheduler for the Monolith permutation: pops one chunk from the chunk FIFO,
// runs it through the permutation core, and streams the result out word by word.
module monolith_chunk_scheduler #(
    parameter int CHUNK_SIZE     = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                                 ACLK,
    input  logic                                 ARESET,
    input  logic                                 enable,
    input  logic                                 fifo_empty,
    input  logic [CHUNK_SIZE-1:0][DATA_WIDTH-1:0] fifo_out,
    output logic                                 fifo_read_strobe,
    output logic                                 perm_start,
    output logic [CHUNK_SIZE-1:0][DATA_WIDTH-1:0] perm_state_in,
    input  logic                                 perm_done,
    input  logic [CHUNK_SIZE-1:0][DATA_WIDTH-1:0] perm_state_out,
    output logic                                 res_tvalid,
    input  logic                                 res_tready,
    output logic [DATA_WIDTH-1:0]                res_tdata,
    output logic                                 res_tlast,
    output logic                                 busy,
    output logic [CNT_WIDTH-1:0]                 chunk_count,
    output logic                                 timeout_err
);

    localparam int IDX_W = $clog2(CHUNK_SIZE);
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHUNK_SIZE - 1);
    localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_LOAD,
        S_START,
        S_BUSY,
        S_EMIT
    } state_t;

    state_t                                state;
    state_t                                state_next;
    logic [CHUNK_SIZE-1:0][DATA_WIDTH-1:0] result;
    logic [IDX_W-1:0]                      word_idx;
    logic [WD_W-1:0]                       watchdog;
    logic                                  beat;

    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next       = state;
        fifo_read_strobe = 1'b0;
        perm_start       = 1'b0;
        res_tvalid       = 1'b0;
        res_tlast        = 1'b0;
        res_tdata        = '0;
        case (state)
            S_IDLE: begin
                if (enable && !fifo_empty) state_next = S_SETTLE;
            end
            S_SETTLE: begin
                state_next = fifo_empty ? S_IDLE : S_LOAD;
            end
            S_LOAD: begin
                fifo_read_strobe = 1'b1;
                state_next       = S_START;
            end
            S_START: begin
                perm_start = 1'b1;
                state_next = S_BUSY;
            end
            S_BUSY: begin
                // Completion wins over an expiring watchdog in the same cycle.
                if (perm_done)                  state_next = S_EMIT;
                else if (watchdog == WD_LIMIT)  state_next = S_IDLE;
            end
            S_EMIT: begin
                res_tvalid = 1'b1;
                res_tdata  = result[word_idx];
                res_tlast  = (word_idx == LAST_IDX);
                if (res_tready && res_tlast) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign beat = res_tvalid && res_tready;
    assign busy = (state != S_IDLE);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of its sources.
    always_ff @(posedge ACLK) begin
        if (ARESET) state <= S_IDLE;
        else        state <= state_next;
    end

    // NOTE: the chunk registers are reset too, so a reset mid-operation
    // cannot leak a stale chunk onto perm_state_in or the result stream.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            perm_state_in <= '0;
            result        <= '0;
            word_idx      <= '0;
            watchdog      <= '0;
            chunk_count   <= '0;
            timeout_err   <= 1'b0;
        end else begin
            if (state == S_LOAD) perm_state_in <= fifo_out;
            if (state == S_START) watchdog <= '0;
            if (state == S_BUSY) begin
                watchdog <= watchdog + WD_W'(1);
                if (perm_done) begin
                    result   <= perm_state_out;
                    word_idx <= '0;
                end else if (watchdog == WD_LIMIT) begin
                    timeout_err <= 1'b1;
                end
            end
            if (beat) begin
                word_idx <= word_idx + IDX_W'(1);
                if (res_tlast) chunk_count <= chunk_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule
